// File: rtl/rand_sched_pkg.sv
// Shared definitions for the time-shared xorshift32 random-number service:
// word width, xorshift shift constants, the reset seed and scheduler states.
package rand_sched_pkg;

    localparam int DATA_W = 32;

    // xorshift32 shift amounts (left, right, left)
    localparam int SH_A = 13;
    localparam int SH_B = 17;
    localparam int SH_C = 5;

    // Seed loaded at reset; also replaces a zero seed, which would lock xorshift at 0
    localparam logic [DATA_W-1:0] DEFAULT_SEED = 32'hEBADD4A9;

    typedef enum logic {
        WARM  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Warm-up counter width: enough to hold 0..warmup, never narrower than one bit
    function automatic int cnt_width(input int warmup);
        return ($clog2(warmup + 1) < 1) ? 1 : $clog2(warmup + 1);
    endfunction

endpackage

// File: rtl/rand_step.sv
// Purely combinational xorshift32 next-state function, shared by every
// generator in the design.
module rand_step
    import rand_sched_pkg::*;
(
    input  logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] s_next
);

    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;

    // Three xor-shift stages; shifts are logical and truncate to DATA_W bits
    always_comb begin
        x1     = s  ^ (s  << SH_A);
        x2     = x1 ^ (x1 >> SH_B);
        s_next = x2 ^ (x2 << SH_C);
    end

endmodule

// File: rtl/rand_sched.sv
// Shared random-number service: one xorshift32 generator time-shared among
// N requesters with round-robin arbitration, runtime reseeding and a warm-up
// run of discarded steps after reset or reseed.
module rand_sched
    import rand_sched_pkg::*;
#(
    parameter int                N            = 4,
    parameter int                WARMUP       = 8,
    parameter logic [DATA_W-1:0] DEFAULT_SEED = rand_sched_pkg::DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      gnt,
    output logic [DATA_W-1:0] rdata,
    input  logic              seed_we,
    input  logic [DATA_W-1:0] seed,
    output logic              busy
);

    localparam int     PTR_W      = $clog2(N);
    localparam int     CNT_W      = cnt_width(WARMUP);
    localparam state_t INIT_STATE = (WARMUP == 0) ? SERVE : WARM;

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  s_q;
    logic [DATA_W-1:0]  s_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   ptr_next;
    logic               last_warm;

    rand_step u_step (
        .s      (s_q),
        .s_next (s_next)
    );

    // Final warm-up step happens when the counter reaches WARMUP-1
    assign last_warm = (WARMUP == 0) || (cnt_q == CNT_W'(WARMUP - 1));

    // State register; reset returns to warm-up (or straight to serving if WARMUP is 0)
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= INIT_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a reseed restarts warm-up; warm-up ends after exactly WARMUP steps
    always_comb begin
        // NOTE: defaulting every combinational output first prevents inferred latches.
        state_d = state_q;
        if (seed_we) begin
            state_d = INIT_STATE;
        end else if (state_q == WARM && last_warm) begin
            state_d = SERVE;
        end
    end

    // Outputs decoded from state: requests are not served while warming up
    always_comb begin
        busy = (state_q == WARM);
    end

    // Round-robin search: first set request at or after ptr, wrapping modulo N
    always_comb begin
        int j;
        logic found;
        j      = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = PTR_W'(j);
            end
        end
        ptr_next = (winner == PTR_W'(N - 1)) ? '0 : winner + 1'b1;
    end

    // Generator, warm-up counter, pointer and registered grant/data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= DEFAULT_SEED;
            cnt_q <= '0;
            ptr_q <= '0;
            gnt   <= '0;
            rdata <= '0;
        end else if (seed_we) begin
            s_q   <= (seed == '0) ? DEFAULT_SEED : seed;
            cnt_q <= '0;
            gnt   <= '0;
        end else if (state_q == WARM) begin
            s_q   <= s_next;
            cnt_q <= cnt_q + 1'b1;
            gnt   <= '0;
        end else if (|req) begin
            gnt   <= {{(N-1){1'b0}}, 1'b1} << winner;
            rdata <= s_q;
            s_q   <= s_next;
            ptr_q <= ptr_next;
        end else begin
            gnt   <= '0;
        end
    end

endmodule

// File: tb/tb_rand_sched.sv
// Self-checking bench for rand_sched: two instances (WARMUP=4 and WARMUP=0)
// share stimulus; every cycle both are compared with a behavioural model, and
// directed tables/sequences add hand-derived expectations.
module tb_rand_sched;
    import rand_sched_pkg::*;

    localparam int N = 4;
    localparam int WARM_A = 4;
    localparam int WARM_B = 0;
    localparam logic [31:0] D = 32'hEBADD4A9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          seed_we = 1'b0;
    logic [31:0]   seed = '0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt_a, gnt_b;
    logic [31:0]   rdata_a, rdata_b;
    logic          busy_a, busy_b;

    rand_sched #(.N(N), .WARMUP(WARM_A)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .rdata(rdata_a),
        .seed_we(seed_we), .seed(seed), .busy(busy_a)
    );

    rand_sched #(.N(N), .WARMUP(WARM_B)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .rdata(rdata_b),
        .seed_we(seed_we), .seed(seed), .busy(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // xorshift32 written with multiply/divide in place of shifts
    function automatic logic [31:0] xs_step(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v * 32'd8192);
        t = t ^ (t / 32'd131072);
        t = t ^ (t * 32'd32);
        return t;
    endfunction

    function automatic logic [31:0] xs_pow(input logic [31:0] v, input int k);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < k; i++) t = xs_step(t);
        return t;
    endfunction

    // Behavioural model: generator value, remaining warm-up steps, rotating pointer
    logic [31:0]  m_s[2];
    int           m_warm[2];
    int           m_ptr[2];
    logic [N-1:0] m_gnt[2];
    logic [31:0]  m_rdata[2];
    int           warm_of[2] = '{WARM_A, WARM_B};

    task automatic model_edge(input int k);
        int w;
        bit found;
        if (rst) begin
            m_s[k] = D; m_warm[k] = warm_of[k]; m_ptr[k] = 0;
            m_gnt[k] = '0; m_rdata[k] = '0;
        end else if (seed_we) begin
            m_s[k] = (seed == 0) ? D : seed;
            m_warm[k] = warm_of[k];
            m_gnt[k] = '0;
        end else if (m_warm[k] > 0) begin
            m_s[k] = xs_step(m_s[k]);
            m_warm[k]--;
            m_gnt[k] = '0;
        end else if (req != 0) begin
            found = 0; w = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && req[(m_ptr[k] + i) % N]) begin
                    found = 1;
                    w = (m_ptr[k] + i) % N;
                end
            end
            m_gnt[k] = '0;
            m_gnt[k][w] = 1'b1;
            m_rdata[k] = m_s[k];
            m_s[k] = xs_step(m_s[k]);
            m_ptr[k] = (w + 1) % N;
        end else begin
            m_gnt[k] = '0;
        end
    endtask

    // One clock: advance the model on the edge, then compare both DUTs 1 ns later
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("a_gnt",   gnt_a,   m_gnt[0]);
        check("a_rdata", rdata_a, m_rdata[0]);
        check("a_busy",  busy_a,  m_warm[0] > 0);
        check("b_gnt",   gnt_b,   m_gnt[1]);
        check("b_rdata", rdata_b, m_rdata[1]);
        check("b_busy",  busy_b,  m_warm[1] > 0);
    endtask

    typedef struct {
        logic         rst;
        logic         we;
        logic [31:0]  seed;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [31:0]  rdata;
        logic         busy;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cycles;

        // Reset with WARMUP=4: busy high exactly four cycles, no grant while warming
        rst = 1'b1; req = '0;
        tick();
        check("a_reset_busy",  busy_a,  1'b1);
        check("a_reset_rdata", rdata_a, 32'h0);
        rst = 1'b0;
        cycles = 0;
        while (busy_a && cycles < 20) begin
            check("a_warm_gnt", gnt_a, '0);
            tick();
            cycles++;
        end
        check("a_busy_len", 32'(cycles), 32'd4);
        req = 4'b0001;
        tick();
        check("a_first_gnt",   gnt_a,   4'b0001);
        check("a_first_rdata", rdata_a, xs_pow(D, 4));
        req = '0;
        tick();

        // Zero seed while serving: no grant, warm-up rerun, first word from default seed
        req = 4'b0010; seed_we = 1'b1; seed = 32'h0;
        tick();
        check("a_reseed_gnt",  gnt_a,  '0);
        check("a_reseed_busy", busy_a, 1'b1);
        seed_we = 1'b0;
        cycles = 0;
        while (busy_a && cycles < 20) begin
            check("a_rewarm_gnt", gnt_a, '0);
            tick();
            cycles++;
        end
        check("a_rebusy_len", 32'(cycles), 32'd4);
        tick();
        check("a_reseed_word_gnt", gnt_a,   4'b0010);
        check("a_reseed_word",     rdata_a, xs_pow(D, 4));
        req = '0;
        tick();

        // Directed table on the WARMUP=0 instance
        tbl.push_back('{1'b1, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'h0,           1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b0001, D,               1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b0010, xs_pow(D, 1),    1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b0100, xs_pow(D, 2),    1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b1000, xs_pow(D, 3),    1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b0001, xs_pow(D, 4),    1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h1, 4'b0100, 4'b0000, xs_pow(D, 4),    1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b0100, 4'b0100, 32'h1,           1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b0100, 4'b0100, 32'h00042021,    1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b0010, 4'b0010, xs_pow(32'h1, 2), 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b0011, 4'b0001, xs_pow(32'h1, 3), 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h5, 4'b0010, 4'b0000, xs_pow(32'h1, 3), 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, xs_pow(32'h1, 3), 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 4'b1111, 4'b0000, 32'h0,           1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b0001, D,               1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 4'b1111, 4'b0010, xs_pow(D, 1),    1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; seed_we = tbl[i].we; seed = tbl[i].seed; req = tbl[i].req;
            tick();
            check($sformatf("tbl%0d_gnt", i),   gnt_b,   tbl[i].gnt);
            check($sformatf("tbl%0d_rdata", i), rdata_b, tbl[i].rdata);
            check($sformatf("tbl%0d_busy", i),  busy_b,  tbl[i].busy);
        end

        // Reset in mid-serve on the WARMUP=4 instance: outputs cleared, warm-up restarts
        rst = 1'b0; seed_we = 1'b0; req = 4'b1111;
        tick();
        rst = 1'b1;
        tick();
        check("a_midrst_gnt",   gnt_a,   '0);
        check("a_midrst_rdata", rdata_a, 32'h0);
        check("a_midrst_busy",  busy_a,  1'b1);
        rst = 1'b0;
        for (int i = 0; i < WARM_A; i++) tick();
        tick();
        check("a_midrst_word_gnt", gnt_a,   4'b0001);
        check("a_midrst_word",     rdata_a, xs_pow(D, 4));

        // Randomized traffic, reseeds and resets against the model
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom_range(0, 79) == 0);
            seed_we = ($urandom_range(0, 39) == 0);
            seed    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            if ($urandom_range(0, 1) == 0) req = N'($urandom_range(0, 15));
            tick();
        end

        rst = 1'b0; seed_we = 1'b0; req = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
